// File: rtl/wb_timer_if.sv
// Pipelined Wishbone bus bundle shared by the CPU interconnect (master)
// and I/O responders (slave). clk/rst are carried for completeness only.
interface if_wb (
    input logic clk,
    input logic rst
);
    logic [15:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        ack;
    logic        stall;

    modport master (
        input  clk, rst,
        output adr, cyc, stb, we, dat_m,
        input  dat_s, ack, stall
    );

    modport slave (
        input  clk, rst,
        input  adr, cyc, stb, we, dat_m,
        output dat_s, ack, stall
    );
endinterface

// File: rtl/wb_timer.sv
// 16-bit prescaled timer/counter with compare match and irq, as a
// pipelined Wishbone slave. Ports: clk, rst_n (async low), wb (slave), irq.
module wb_timer #(
    parameter logic [15:0] PRESC_RST = 16'h0000,
    parameter logic [15:0] CMP_RST   = 16'hFFFF
) (
    input  logic clk,
    input  logic rst_n,
    if_wb.slave  wb,
    output logic irq
);
    logic        r_en, r_per, r_ien, r_match;
    logic [15:0] r_presc, r_cmp, r_cnt, r_pcnt;
    logic        r_ack;
    logic [15:0] r_dat;

    logic        w_acc, w_wr;
    logic [1:0]  w_sel;
    logic        w_wr_ctrl, w_wr_presc, w_wr_cmp, w_wr_cnt;
    logic        w_tick, w_hit;
    logic [15:0] w_rdata;
    logic        w_unused;

    assign w_acc      = wb.cyc & wb.stb;
    assign w_wr       = w_acc & wb.we;
    assign w_sel      = wb.adr[2:1];
    assign w_wr_ctrl  = w_wr && (w_sel == 2'd0);
    assign w_wr_presc = w_wr && (w_sel == 2'd1);
    assign w_wr_cmp   = w_wr && (w_sel == 2'd2);
    assign w_wr_cnt   = w_wr && (w_sel == 2'd3);

    assign w_tick = r_en && (r_pcnt == r_presc);
    assign w_hit  = w_tick && (r_cnt == r_cmp);

    assign w_unused = ^{wb.adr[15:3], wb.adr[0], wb.clk, wb.rst};

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            2'd0:    w_rdata = {r_match, 12'd0, r_ien, r_per, r_en};
            2'd1:    w_rdata = r_presc;
            2'd2:    w_rdata = r_cmp;
            default: w_rdata = r_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_en    <= 1'b0;
            r_per   <= 1'b0;
            r_ien   <= 1'b0;
            r_match <= 1'b0;
            r_presc <= PRESC_RST;
            r_cmp   <= CMP_RST;
            r_cnt   <= '0;
            r_pcnt  <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wb.we) ? w_rdata : 16'h0000;

            if (w_wr_presc) r_presc <= wb.dat_m;
            if (w_wr_cmp)   r_cmp   <= wb.dat_m;

            if (w_wr_ctrl) begin
                r_per <= wb.dat_m[1];
                r_ien <= wb.dat_m[2];
            end

            // Bus write of EN wins over the one-shot auto-stop
            if (w_wr_ctrl)
                r_en <= wb.dat_m[0];
            else if (w_hit && !r_per)
                r_en <= 1'b0;

            // A new match wins over a simultaneous W1C
            if (w_hit)
                r_match <= 1'b1;
            else if (w_wr_ctrl && wb.dat_m[15])
                r_match <= 1'b0;

            if (w_wr_cnt)
                r_cnt <= wb.dat_m;
            else if (w_tick) begin
                if (w_hit)
                    r_cnt <= r_per ? 16'h0000 : r_cnt;
                else
                    r_cnt <= r_cnt + 16'd1;
            end

            // Free-runs past a lowered PRESC and wraps at FFFF
            if (w_wr_cnt || !r_en || w_tick)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + 16'd1;
        end
    end

    assign wb.ack   = r_ack;
    assign wb.dat_s = r_dat;
    assign wb.stall = 1'b0;
    assign irq      = r_match & r_ien;
endmodule

// File: doc/wb_timer.md
# wb_timer

Pipelined-Wishbone responder hosting a 16-bit prescaled timer/counter with compare match and interrupt. It sits behind the CPU-side Wishbone interconnect on one of the I/O slave ports. It answers every accepted request with exactly one registered ack. It is the slave end of the same bus the interconnect drives as master.

## Interface
Parameters:
- PRESC_RST, 16'h0000, reset value of PRESC.
- CMP_RST, 16'hFFFF, reset value of CMP.

Ports:
- clk  input  1  single clock for all sequential logic.
- rst_n  input  1  asynchronous, active-low reset.
- wb  if_wb.slave  —  bus port. wb.clk and wb.rst are not used; clk and rst_n govern all logic.
- wb.adr  input  16  register select on adr[2:1]; other bits ignored.
- wb.cyc, wb.stb, wb.we  input  1 each  bus cycle, strobe, write enable.
- wb.dat_m  input  16  write data.
- wb.dat_s  output  16  read data, registered.
- wb.ack  output  1  registered acknowledge.
- wb.stall  output  1  tied 0.
- irq  output  1  MATCH & IRQ_EN.

## Operation
- Register map (adr[2:1]):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, bit15 MATCH (read; write 1 clears, write 0 no effect); bits 14:3 read 0.
  - 1 PRESC: divider; tick every PRESC+1 enabled clocks.
  - 2 CMP: compare value.
  - 3 CNT: read = counter; write = load counter and clear prescaler.
- Accept = cyc & stb (stall is always 0). Every accepted request produces ack=1 on the next cycle.
- Writes (we=1) update the register at the accepting edge. Reads capture the pre-edge register value into dat_s. dat_s is 0 on write cycles.
- Prescaler pcnt: when EN=1, increments each clock. When pcnt==PRESC, pcnt←0 and tick=1. When EN=0, pcnt holds 0.
- On tick:
  - CNT==CMP: match event, MATCH←1.
    - PERIODIC=1: CNT←0.
    - PERIODIC=0: EN←0, CNT holds.
  - Otherwise CNT←CNT+1, wrapping 16'hFFFF→16'h0000.
- Priority on simultaneous events:
  - Bus write to CNT beats the tick update. pcnt←0.
  - Match-set of MATCH beats W1C clear; MATCH stays 1.
  - Bus write of EN beats one-shot auto-clear.
  - Write to PRESC takes effect immediately. If pcnt>new PRESC, pcnt counts up and wraps at 16'hFFFF to 0 with no tick.
- irq is combinational from flops only; no bus path to irq.

## Timing
- Reset (rst_n low, async): ack=0, dat_s=0, stall=0, irq=0, CTRL=0, PRESC=PRESC_RST, CMP=CMP_RST, CNT=0, pcnt=0. Reset asserted mid-transaction drops a pending ack immediately; the request is not acknowledged.
- Latency: ack and dat_s valid exactly 1 cycle after accept. Back-to-back accepts give back-to-back acks in order; there is no throughput limit.
- ack is issued even if cyc is deasserted in the ack cycle.
- Enable to first tick: EN written at edge E; pcnt=0 in the cycle after E; first tick edge at E+PRESC+1.
- MATCH becomes visible (and irq rises) the cycle after the tick edge. A read accepted in that cycle returns it one cycle later.

## Test plan
- Reset values: pulse rst_n low, then read addresses 0..3 → dat_s 0000/PRESC_RST/FFFF/0000. Each ack occurs 1 cycle after stb; stall stays 0.
- Pipelined burst: 4 reads on 4 consecutive cycles (CNT, CMP, PRESC, CTRL) → 4 consecutive ack cycles, data in issue order. A write burst is likewise acked 1:1.
- Periodic run: PRESC=3, CMP=5, CTRL=0x0007 → CNT steps every 4 clocks through 0..5. The match event is the 6th tick, 24 clocks after the enabling write. CNT→0, MATCH=1, irq=1, and counting continues.
- One-shot: PRESC=0, CMP=2, CTRL=0x0001 → CNT 0,1,2 on successive clocks. On the next tick EN→0 and CNT holds 2. MATCH=1, irq=0. CTRL reads 0x8000.
- Races:
  - W1C of MATCH on the match-event edge → MATCH stays 1.
  - Write CNT=0x1234 on a tick edge → CNT reads 0x1234, and the next tick comes PRESC+1 clocks later.
  - CNT=FFFF with CMP≠FFFF → wraps to 0000 with no MATCH.
- Async reset mid-run: periodic timer running with a read outstanding; assert rst_n → ack, irq, and dat_s go 0 without a clock edge, and all registers return to reset values.
